cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Sequencer that owns the CPU's run lifecycle. It holds the CPU in reset, streams a program into the 16-byte instruction memory over a valid/ready byte interface, releases the CPU, and counts executed cycles. It stops when the CPU halts or when a cycle budget expires. It sits between the host/test harness and the cpu instance and drives the CPU reset and the imem write port.

Parameters:
IMEM_DEPTH, 16, instruction memory depth in bytes; must be a power of two
ADDR_W, 4, imem address width; equals log2(IMEM_DEPTH)
CNT_W, 16, width of the cycle counter and of the budget

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin load+run; sampled only in IDLE, DONE, TIMEOUT
abort  in  1  return to IDLE from any state; highest priority after rst_n
max_cycles  in  CNT_W  run budget; 0 = unlimited; sampled on the start edge
prog_valid  in  1  program byte valid
prog_data  in  8  program byte
prog_last  in  1  final byte of program; qualified by prog_valid
prog_ready  out  1  controller accepts byte
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  imem write address
imem_wdata  out  8  imem write data
cpu_halt  in  1  halt output of the CPU
cpu_rst  out  1  active-high reset to the CPU; registered
busy  out  1  state is LOAD or RUN
done  out  1  state is DONE
timeout  out  1  state is TIMEOUT
trunc  out  1  sticky: load ended at full depth without prog_last
cycle_count  out  CNT_W  CPU cycles executed in the current or last run

Behaviour:
- Reset (rst_n=0, async): state=IDLE, cpu_rst=1, prog_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=done=timeout=trunc=0, cycle_count=0, budget register=0.
- States: IDLE, LOAD, RUN, DONE, TIMEOUT.
- IDLE: cpu_rst=1. On start: go to LOAD; imem_addr:=0, trunc:=0, budget:=max_cycles.
- LOAD: cpu_rst=1, prog_ready=1 (registered, asserted the first cycle in LOAD).
  - Beat = prog_valid & prog_ready.
  - Per beat, the registered write appears the next cycle: imem_we=1 for one cycle, imem_wdata=prog_data, imem_addr=current index. The index increments after each write and wraps modulo IMEM_DEPTH.
  - Beat with prog_last: leave LOAD.
  - Beat at index IMEM_DEPTH-1 without prog_last: leave LOAD and set trunc=1.
  - On leaving LOAD: prog_ready=0 on the same edge, and no further beats are accepted.
  - Unwritten imem locations keep their old contents.
- LOAD→RUN: first completes the final imem write, then cpu_rst:=0 on the following edge. The last write therefore always lands before the CPU leaves reset. cycle_count:=0 on entry.
- RUN: cpu_rst=0. Evaluated each rising edge, in this priority order:
  1. cpu_halt=1: go to DONE; cycle_count holds.
  2. budget≠0 and cycle_count==budget: go to TIMEOUT; cpu_rst:=1.
  3. Otherwise: cycle_count+1, saturating at all-ones.
- Consequence: a program whose first instruction is HLT (0xF0) ends with cycle_count=1. Halt seen in the same cycle as the budget hit gives DONE, not TIMEOUT.
- DONE: cpu_rst stays 0 so the halted CPU's pc/acc remain observable. done=1.
- TIMEOUT: cpu_rst=1. timeout=1.
- In both DONE and TIMEOUT, cycle_count and trunc hold. On start, go to LOAD (as from IDLE).
- start is ignored in LOAD and RUN.
- abort (synchronous, any state): next state IDLE, cpu_rst:=1, prog_ready:=0, no imem write issued. cycle_count and trunc hold.
- abort and start in the same cycle: abort wins.
- rst_n asserted mid-load or mid-run: immediate return to reset values. A partially loaded imem is not cleared.
- busy, done and timeout are decoded from the registered state; they are glitch-free and mutually exclusive.

Test Plan:
1. Reset, start with max_cycles=0, stream 0x53,0x20,0x1F… ending with 0xF0 plus prog_last as the 4th byte → imem_we pulses at addresses 0..3 with matching data; cpu_rst falls 1 cycle after the last write; DONE with cycle_count=4; CPU acc=3.
2. Program single byte 0xF0 with prog_last → DONE, cycle_count=1, busy low.
3. Program 0x60 (JMP 0) only, max_cycles=10 → TIMEOUT after cycle_count reaches 10; cpu_rst back to 1 on the same edge; timeout=1.
4. Stream 16 bytes without prog_last, with prog_valid held high through the 17th cycle → exactly 16 writes at addresses 0..15; trunc=1; prog_ready low after the 16th beat; the 17th byte is not accepted.
5. prog_valid gapped (valid every 3rd cycle) and an abort mid-LOAD after 2 bytes → only 2 writes; IDLE; cpu_rst=1; a following start reloads from address 0.
6. Budget hit and cpu_halt on the same edge (HLT placed so that cycle_count==max_cycles as halt rises) → DONE, not TIMEOUT. rst_n pulsed low during RUN → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run-lifecycle sequencer: holds the CPU in reset, streams a program into imem,
// releases the CPU and counts executed cycles until halt or budget expiry.
module cpu_run_ctrl #(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic              prog_valid,
  input  logic [7:0]        prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  input  logic              cpu_halt,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              trunc,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  budget;
  logic              beat, at_end, load_exit, budget_hit;

  assign beat       = prog_valid & prog_ready;
  assign at_end     = (idx == ADDR_W'(IMEM_DEPTH - 1));
  assign load_exit  = beat & (prog_last | at_end);
  assign budget_hit = (budget != '0) && (cycle_count == budget);

  assign busy    = (state == S_LOAD) || (state == S_RUN);
  assign done    = (state == S_DONE);
  assign timeout = (state == S_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // In RUN, cpu_rst still high marks the release cycle: the final imem write
  // lands on that edge, so nothing is counted or checked yet.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: if (start) state_nxt = S_LOAD;
        S_LOAD:                    if (load_exit) state_nxt = S_RUN;
        S_RUN: begin
          if (!cpu_rst) begin
            if (cpu_halt)        state_nxt = S_DONE;
            else if (budget_hit) state_nxt = S_TIMEOUT;
          end
        end
        default:                   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst     <= 1'b1;
      prog_ready  <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      idx         <= '0;
      budget      <= '0;
      trunc       <= 1'b0;
      cycle_count <= '0;
    end else begin
      imem_we <= 1'b0;
      if (abort) begin
        cpu_rst    <= 1'b1;
        prog_ready <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_TIMEOUT: begin
            if (start) begin
              idx        <= '0;
              imem_addr  <= '0;
              trunc      <= 1'b0;
              budget     <= max_cycles;
              prog_ready <= 1'b1;
              cpu_rst    <= 1'b1;
            end
          end
          S_LOAD: begin
            if (beat) begin
              imem_we    <= 1'b1;
              imem_addr  <= idx;
              imem_wdata <= prog_data;
              idx        <= idx + ADDR_W'(1);
            end
            if (load_exit) begin
              prog_ready  <= 1'b0;
              trunc       <= ~prog_last;
              cycle_count <= '0;
            end
          end
          S_RUN: begin
            if (cpu_rst)                 cpu_rst <= 1'b0;
            else if (cpu_halt)           ;
            else if (budget_hit)         cpu_rst <= 1'b1;
            else if (cycle_count != '1)  cycle_count <= cycle_count + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny CPU stand-in and an imem-write scoreboard.
module tb_cpu_run_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, prog_valid, prog_last, cpu_halt;
  logic [CNT_W-1:0] max_cycles;
  logic [7:0]       prog_data, imem_wdata;
  logic [3:0]       imem_addr;
  logic             prog_ready, imem_we, cpu_rst, busy, done, timeout, trunc;
  logic [CNT_W-1:0] cycle_count;

  cpu_run_ctrl #(.IMEM_DEPTH(16), .ADDR_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_cycles(max_cycles),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_last(prog_last),
    .prog_ready(prog_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_halt(cpu_halt), .cpu_rst(cpu_rst), .busy(busy),
    .done(done), .timeout(timeout), .trunc(trunc), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // imem plus a minimal CPU: F0 halts, 6x jumps to x, anything else steps pc
  logic [7:0] mem [16];
  logic [3:0] pc;
  logic [7:0] op;
  assign op = mem[pc];

  always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

  always @(posedge clk) begin
    if (cpu_rst) begin
      pc <= 4'd0; cpu_halt <= 1'b0;
    end else if (!cpu_halt) begin
      if (op == 8'hF0)          cpu_halt <= 1'b1;
      else if (op[7:4] == 4'h6) pc <= op[3:0];
      else                      pc <= pc + 4'd1;
    end
  end

  int n_cmp = 0, n_fail = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  exp_addr;
  logic [7:0]  pbuf [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every imem write must match the next pushed beat
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) chk("write_expected", exp_q.size(), 1);
      else chk("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] mc);
    max_cycles = mc; start = 1'b1;
    tick();
    start = 1'b0; exp_addr = 4'd0;
  endtask

  task automatic send(input int n, input bit last, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin prog_valid = 1'b0; tick(); end
      prog_valid = 1'b1; prog_data = pbuf[i]; prog_last = last && (i == n - 1);
      begin
        int w = 0;
        while (!prog_ready && w < 20) begin tick(); w++; end
        if (w == 20) chk("ready_wait", prog_ready, 1);
      end
      exp_q.push_back({exp_addr, pbuf[i]});
      exp_addr++;
      tick();
    end
    prog_valid = 1'b0; prog_last = 1'b0;
  endtask

  task automatic wait_not_busy();
    int w = 0;
    while (busy && w < 300) begin tick(); w++; end
    if (w == 300) chk("run_end_wait", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0; start = 0; abort = 0; prog_valid = 0; prog_last = 0;
    prog_data = 8'h00; max_cycles = '0; exp_addr = 4'd0;
    #12;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_busy", {busy, done, timeout, trunc}, 0);
    chk("rst_ready_we", {prog_ready, imem_we}, 0);
    chk("rst_addr_data", {imem_addr, imem_wdata}, 0);
    chk("rst_count", cycle_count, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: four-byte program ending in HLT, unlimited budget
    pbuf[0] = 8'h53; pbuf[1] = 8'h20; pbuf[2] = 8'h1F; pbuf[3] = 8'hF0;
    do_start(16'd0);
    chk("t1_ready_first", prog_ready, 1);
    chk("t1_busy", busy, 1);
    send(4, 1'b1, 0);
    chk("t1_last_we", {imem_we, imem_addr, prog_ready}, {1'b1, 4'd3, 1'b0});
    chk("t1_cpu_rst_held", cpu_rst, 1);
    tick();
    chk("t1_cpu_rst_released", cpu_rst, 0);
    wait_not_busy();
    chk("t1_done", {done, timeout}, 2'b10);
    chk("t1_count", cycle_count, 4);
    chk("t1_cpu_rst_done", cpu_rst, 0);
    chk("t1_trunc", trunc, 0);

    // 2: single HLT
    pbuf[0] = 8'hF0;
    do_start(16'd0);
    chk("t2_cpu_rst_reasserted", cpu_rst, 1);
    send(1, 1'b1, 0);
    wait_not_busy();
    chk("t2_done", {busy, done}, 2'b01);
    chk("t2_count", cycle_count, 1);

    // 3: JMP 0 loop against a budget of 10; start during RUN is ignored
    pbuf[0] = 8'h60;
    do_start(16'd10);
    send(1, 1'b1, 0);
    tick(); tick(); tick();
    max_cycles = 16'd2; start = 1'b1; tick(); start = 1'b0;
    chk("t3_start_ignored", {busy, cpu_rst}, 2'b10);
    wait_not_busy();
    chk("t3_timeout", {done, timeout}, 2'b01);
    chk("t3_count", cycle_count, 10);
    chk("t3_cpu_rst", cpu_rst, 1);

    // 4: 16 bytes without prog_last, valid held into a 17th
    for (int i = 0; i < 16; i++) pbuf[i] = 8'h30 + 8'(i);
    do_start(16'd3);
    send(16, 1'b0, 0);
    prog_valid = 1'b1; prog_data = 8'hAA;
    chk("t4_ready_low", prog_ready, 0);
    chk("t4_trunc", trunc, 1);
    tick(); tick();
    prog_valid = 1'b0;
    chk("t4_write_count", exp_q.size(), 0);
    wait_not_busy();
    chk("t4_trunc_held", {trunc, timeout}, 2'b11);

    // 5: gapped load, abort with a byte on the bus, then reload from 0
    pbuf[0] = 8'h11; pbuf[1] = 8'h22;
    do_start(16'd0);
    send(2, 1'b0, 2);
    prog_valid = 1'b1; prog_data = 8'h33; abort = 1'b1;
    tick();
    abort = 1'b0; prog_valid = 1'b0;
    chk("t5_idle", {busy, done, timeout}, 0);
    chk("t5_cpu_rst_ready", {cpu_rst, prog_ready}, 2'b10);
    tick(); tick();
    chk("t5_write_count", exp_q.size(), 0);
    pbuf[0] = 8'hF0;
    do_start(16'd0);
    send(1, 1'b1, 0);
    wait_not_busy();
    chk("t5_reload_done", {done, cycle_count}, {1'b1, 16'd1});

    // abort beats start from DONE
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("abort_over_start", {busy, done, cpu_rst}, 3'b001);

    // 6: halt and budget hit on the same edge
    pbuf[0] = 8'h53; pbuf[1] = 8'h20; pbuf[2] = 8'h1F; pbuf[3] = 8'hF0;
    do_start(16'd4);
    send(4, 1'b1, 0);
    wait_not_busy();
    chk("t6_done_not_timeout", {done, timeout}, 2'b10);
    chk("t6_count", cycle_count, 4);

    // async reset in the middle of a run
    pbuf[0] = 8'h60;
    do_start(16'd0);
    send(1, 1'b1, 0);
    repeat (5) tick();
    chk("t6_running", {busy, cpu_rst}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_state", {busy, done, timeout, trunc, cpu_rst}, 5'b00001);
    chk("t6_arst_count", cycle_count, 0);
    chk("t6_arst_io", {prog_ready, imem_we, imem_addr, imem_wdata}, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
